// File: rtl/nes_tetris_input_pkg.sv
// rtl/nes_tetris_input_pkg.sv - key classes, DAS state encoding and default HID codes
package nes_tetris_input_pkg;

   localparam logic [2:0] CLS_NONE  = 3'd0;
   localparam logic [2:0] CLS_LEFT  = 3'd1;
   localparam logic [2:0] CLS_RIGHT = 3'd2;
   localparam logic [2:0] CLS_DOWN  = 3'd3;
   localparam logic [2:0] CLS_CW    = 3'd4;
   localparam logic [2:0] CLS_CCW   = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DAS_WAIT,
      ST_DAS_RPT,
      ST_DROP,
      ST_HOLD
   } das_state_t;

   localparam logic [7:0] DEF_KEY_LEFT    = 8'h04;
   localparam logic [7:0] DEF_KEY_RIGHT   = 8'h07;
   localparam logic [7:0] DEF_KEY_DOWN    = 8'h16;
   localparam logic [7:0] DEF_KEY_ROT_CW  = 8'h0E;
   localparam logic [7:0] DEF_KEY_ROT_CCW = 8'h0D;

   localparam int NUM_CMD = 5;

   // Bit order: {rot_ccw, rot_cw, soft_drop, move_right, move_left}
   typedef logic [NUM_CMD-1:0] cmd_vec_t;

   function automatic cmd_vec_t cls_to_cmd(input logic [2:0] cls);
      cmd_vec_t cmd;
      cmd = '0;
      case (cls)
         CLS_LEFT:  cmd[0] = 1'b1;
         CLS_RIGHT: cmd[1] = 1'b1;
         CLS_DOWN:  cmd[2] = 1'b1;
         CLS_CW:    cmd[3] = 1'b1;
         CLS_CCW:   cmd[4] = 1'b1;
         default:   cmd = '0;
      endcase
      return cmd;
   endfunction

   function automatic das_state_t cls_entry_state(input logic [2:0] cls);
      das_state_t st;
      case (cls)
         CLS_LEFT, CLS_RIGHT: st = ST_DAS_WAIT;
         CLS_DOWN:            st = ST_DROP;
         CLS_CW, CLS_CCW:     st = ST_HOLD;
         default:             st = ST_IDLE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/nes_tetris_das_ctrl_if.sv
// rtl/nes_tetris_das_ctrl_if.sv - keycode/frame inputs and command pulse outputs
interface nes_tetris_das_ctrl_if;

   logic [7:0] keycode;
   logic       frame_tick;
   logic       enable;
   logic       move_left;
   logic       move_right;
   logic       soft_drop;
   logic       rot_cw;
   logic       rot_ccw;

   modport master (
      output keycode, frame_tick, enable,
      input  move_left, move_right, soft_drop, rot_cw, rot_ccw
   );

   modport slave (
      input  keycode, frame_tick, enable,
      output move_left, move_right, soft_drop, rot_cw, rot_ccw
   );

endinterface

// File: rtl/nes_tetris_key_decode.sv
// rtl/nes_tetris_key_decode.sv - combinational HID keycode to key class mapping
module nes_tetris_key_decode
   import nes_tetris_input_pkg::*;
#(
   parameter logic [7:0] KEY_LEFT    = DEF_KEY_LEFT,
   parameter logic [7:0] KEY_RIGHT   = DEF_KEY_RIGHT,
   parameter logic [7:0] KEY_DOWN    = DEF_KEY_DOWN,
   parameter logic [7:0] KEY_ROT_CW  = DEF_KEY_ROT_CW,
   parameter logic [7:0] KEY_ROT_CCW = DEF_KEY_ROT_CCW
) (
   input  logic [7:0] keycode,
   output logic [2:0] key_class
);

   // 8'h00 means no key even if a KEY_* parameter were set to zero
   always_comb begin
      key_class = CLS_NONE;
      if (keycode != 8'h00) begin
         if      (keycode == KEY_LEFT)    key_class = CLS_LEFT;
         else if (keycode == KEY_RIGHT)   key_class = CLS_RIGHT;
         else if (keycode == KEY_DOWN)    key_class = CLS_DOWN;
         else if (keycode == KEY_ROT_CW)  key_class = CLS_CW;
         else if (keycode == KEY_ROT_CCW) key_class = CLS_CCW;
      end
   end

endmodule

// File: rtl/nes_tetris_das_ctrl.sv
// rtl/nes_tetris_das_ctrl.sv - per-frame move/drop/rotate commands with NES-style DAS
module nes_tetris_das_ctrl
   import nes_tetris_input_pkg::*;
#(
   parameter logic [7:0] KEY_LEFT    = DEF_KEY_LEFT,
   parameter logic [7:0] KEY_RIGHT   = DEF_KEY_RIGHT,
   parameter logic [7:0] KEY_DOWN    = DEF_KEY_DOWN,
   parameter logic [7:0] KEY_ROT_CW  = DEF_KEY_ROT_CW,
   parameter logic [7:0] KEY_ROT_CCW = DEF_KEY_ROT_CCW,
   parameter int         DAS_INIT    = 16,
   parameter int         DAS_REPEAT  = 6,
   parameter int         DROP_PERIOD = 2,
   parameter int         CNT_W       = 5
) (
   input  logic           clk,
   input  logic           reset_n,
   nes_tetris_das_ctrl_if.slave bus
);

   localparam logic [CNT_W:0] INIT_M = (CNT_W+1)'(DAS_INIT);
   localparam logic [CNT_W:0] RPT_M  = (CNT_W+1)'(DAS_REPEAT);
   localparam logic [CNT_W:0] DROP_M = (CNT_W+1)'(DROP_PERIOD);
   localparam logic [CNT_W:0] ONE_M  = (CNT_W+1)'(1);

   logic [2:0]       key_class;
   logic [2:0]       prev_class;
   das_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   cnt_inc;
   logic             period_hit;
   cmd_vec_t         cmd_q;

   nes_tetris_key_decode #(
      .KEY_LEFT    (KEY_LEFT),
      .KEY_RIGHT   (KEY_RIGHT),
      .KEY_DOWN    (KEY_DOWN),
      .KEY_ROT_CW  (KEY_ROT_CW),
      .KEY_ROT_CCW (KEY_ROT_CCW)
   ) u_decode (
      .keycode   (bus.keycode),
      .key_class (key_class)
   );

   // One bit wider than cnt so the period compare never sees a wrapped value
   assign cnt_inc = {1'b0, cnt} + ONE_M;

   always_comb begin
      period_hit = 1'b0;
      case (state)
         ST_DAS_WAIT: period_hit = (cnt_inc == INIT_M);
         ST_DAS_RPT:  period_hit = (cnt_inc == RPT_M);
         ST_DROP:     period_hit = (cnt_inc == DROP_M);
         default:     period_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         prev_class <= CLS_NONE;
         cmd_q      <= '0;
      end else begin
         cmd_q <= '0;
         if (!bus.enable) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            prev_class <= CLS_NONE;
         end else if (bus.frame_tick) begin
            prev_class <= key_class;
            if (key_class == CLS_NONE) begin
               state <= ST_IDLE;
               cnt   <= '0;
            end else if (key_class != prev_class) begin
               cmd_q <= cls_to_cmd(key_class);
               cnt   <= '0;
               state <= cls_entry_state(key_class);
            end else begin
               case (state)
                  ST_DAS_WAIT, ST_DAS_RPT, ST_DROP: begin
                     if (period_hit) begin
                        cmd_q <= cls_to_cmd(key_class);
                        cnt   <= '0;
                        if (state == ST_DAS_WAIT) state <= ST_DAS_RPT;
                     end else begin
                        cnt <= cnt_inc[CNT_W-1:0];
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   end

   assign bus.move_left  = cmd_q[0];
   assign bus.move_right = cmd_q[1];
   assign bus.soft_drop  = cmd_q[2];
   assign bus.rot_cw     = cmd_q[3];
   assign bus.rot_ccw    = cmd_q[4];

endmodule

// File: tb/tb_nes_tetris_das_ctrl.sv
// tb/tb_nes_tetris_das_ctrl.sv - scoreboard bench for nes_tetris_das_ctrl
module tb_nes_tetris_das_ctrl;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   nes_tetris_das_ctrl_if bus ();

   nes_tetris_das_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [4:0] exp_q[$];

   // Reference: class held and number of ticks since it was pressed
   int m_prev = 0;
   int m_n = 0;

   function automatic int decode(input logic [7:0] k);
      case (k)
         8'h04:   return 1;
         8'h07:   return 2;
         8'h16:   return 3;
         8'h0E:   return 4;
         8'h0D:   return 5;
         default: return 0;
      endcase
   endfunction

   function automatic logic [4:0] model_tick(input logic [7:0] k, input logic en);
      logic [4:0] e;
      int c;
      e = 5'b0;
      c = decode(k);
      if (!en || c == 0) begin
         m_prev = 0;
      end else if (c != m_prev) begin
         m_prev = c;
         m_n = 0;
         e = 5'b1 << (c - 1);
      end else begin
         m_n++;
         if ((c == 1 || c == 2) && m_n >= 16 && ((m_n - 16) % 6) == 0) e = 5'b1 << (c - 1);
         if (c == 3 && (m_n % 2) == 0) e = 5'b00100;
      end
      return e;
   endfunction

   function automatic logic [4:0] outs();
      return {bus.rot_ccw, bus.rot_cw, bus.soft_drop, bus.move_right, bus.move_left};
   endfunction

   task automatic tick(input logic [7:0] k, input logic en);
      @(negedge clk);
      bus.keycode    = k;
      bus.enable     = en;
      bus.frame_tick = 1'b1;
      exp_q.push_back(model_tick(k, en));
      @(negedge clk);
      bus.frame_tick = 1'b0;
      bus.keycode    = 8'($urandom);
      repeat (2) begin
         @(negedge clk);
         bus.keycode = 8'($urandom);
      end
   endtask

   task automatic ticks(input logic [7:0] k, input int n, input logic en);
      for (int i = 0; i < n; i++) tick(k, en);
   endtask

   // Tick, then pulse reset for one clock while the resulting command is high
   task automatic tick_reset(input logic [7:0] k);
      @(negedge clk);
      bus.keycode    = k;
      bus.enable     = 1'b1;
      bus.frame_tick = 1'b1;
      exp_q.push_back(model_tick(k, 1'b1));
      @(negedge clk);
      bus.frame_tick = 1'b0;
      reset_n = 1'b0;
      #1;
      checks++;
      if (outs() !== 5'b0) begin
         errors++;
         $display("FAIL reset_mid_pulse got=%b exp=%b", outs(), 5'b0);
      end
      m_prev = 0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin : monitor
      logic       tick_seen;
      logic [4:0] got;
      logic [4:0] e;
      forever begin
         @(posedge clk);
         tick_seen = bus.frame_tick;
         #1;
         got = outs();
         checks++;
         if (tick_seen) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_underflow got=%b exp=<none>", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display("FAIL cmd_after_tick t=%0t got=%b exp=%b", $time, got, e);
               end
            end
         end else if (got !== 5'b0) begin
            errors++;
            $display("FAIL idle_cycle_pulse t=%0t got=%b exp=%b", $time, got, 5'b0);
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] keys [8];
      logic [7:0] k;
      logic       en;
      keys[0] = 8'h00; keys[1] = 8'h04; keys[2] = 8'h07; keys[3] = 8'h16;
      keys[4] = 8'h0E; keys[5] = 8'h0D; keys[6] = 8'h2C; keys[7] = 8'h04;

      bus.keycode    = 8'h00;
      bus.frame_tick = 1'b0;
      bus.enable     = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (outs() !== 5'b0) begin
         errors++;
         $display("FAIL reset_state got=%b exp=%b", outs(), 5'b0);
      end
      reset_n = 1'b1;

      ticks(8'h04, 40, 1'b1);  tick(8'h00, 1'b1);
      ticks(8'h16, 7, 1'b1);   ticks(8'h00, 2, 1'b1);
      ticks(8'h16, 3, 1'b1);   tick(8'h00, 1'b1);
      ticks(8'h0E, 10, 1'b1);  ticks(8'h0D, 3, 1'b1);  tick(8'h00, 1'b1);
      ticks(8'h04, 10, 1'b1);  ticks(8'h07, 20, 1'b1); tick(8'h00, 1'b1);
      ticks(8'h07, 5, 1'b1);   ticks(8'h07, 3, 1'b0);  ticks(8'h07, 20, 1'b1);
      tick(8'h00, 1'b1);
      ticks(8'h2C, 10, 1'b1);
      ticks(8'h04, 22, 1'b1);  tick_reset(8'h04);
      ticks(8'h04, 8, 1'b1);   tick(8'h00, 1'b1);
      ticks(8'h16, 1, 1'b1);   tick_reset(8'h16);  ticks(8'h16, 3, 1'b1);

      for (int s = 0; s < 150; s++) begin
         k  = keys[$urandom_range(0, 7)];
         if ($urandom_range(0, 9) == 0) k = 8'($urandom);
         for (int i = 0; i < int'($urandom_range(1, 24)); i++) begin
            en = ($urandom_range(0, 15) != 0);
            tick(k, en);
         end
      end

      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
